// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed data memory with a load/store unit, valid/ready requests,
// LATENCY wait states, RV32 lane select/extension and fault reporting. Optional macro DMEM_MISALIGN_EN.
module dmem_lsu #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_f3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 1 << WORD_W;

    typedef enum logic [1:0] {IDLE, WAIT, ACC, ACC2} state_t;

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         lo_q;

    logic [31:0]         mem [DEPTH];

    logic [WORD_W-1:0]   word_lo;
    logic [WORD_W-1:0]   word_hi;
    logic [1:0]          off;
    logic                is_h;
    logic                is_w;
    logic                f3_ok;
    logic                split;
    logic                fault;
    logic                commit;
    logic [7:0]          size_mask;
    logic [7:0]          lane_mask;
    logic [63:0]         wide_wdata;
    logic [31:0]         lo_word;
    logic [63:0]         span;
    logic [31:0]         raw;
    logic [31:0]         ext;

    // Request decode: legality, lane mask and the two-word window used by loads and stores
    always_comb begin
        word_lo = addr_q[ADDR_W-1:2];
        word_hi = word_lo + WORD_W'(1);
        off     = addr_q[1:0];
        is_h    = (f3_q[1:0] == 2'b01);
        is_w    = (f3_q[1:0] == 2'b10);
        f3_ok   = we_q ? (f3_q == 3'b000 || f3_q == 3'b001 || f3_q == 3'b010)
                       : (f3_q == 3'b000 || f3_q == 3'b001 || f3_q == 3'b010 ||
                          f3_q == 3'b100 || f3_q == 3'b101);
`ifdef DMEM_MISALIGN_EN
        split   = f3_ok && ((is_h && off == 2'b11) || (is_w && off != 2'b00));
        fault   = !f3_ok;
`else
        split   = 1'b0;
        fault   = !f3_ok || (is_h && off[0]) || (is_w && off != 2'b00);
`endif
        size_mask  = is_w ? 8'h0F : (is_h ? 8'h03 : 8'h01);
        lane_mask  = size_mask << off;
        wide_wdata = 64'(wdata_q) << {off, 3'b000};
        lo_word    = (state == ACC2) ? lo_q : mem[word_lo];
        span       = {mem[word_hi], lo_word};
        raw        = 32'(span >> {off, 3'b000});
        case (f3_q)
            3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ext = {24'd0, raw[7:0]};
            3'b101:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
        commit = we_q && !fault && ((state == ACC && !split) || state == ACC2);
    end

    // Storage is never reset; both word halves of a split store commit on the completing edge
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i])
                    mem[word_lo][8*i +: 8] <= wide_wdata[8*i +: 8];
                if (lane_mask[i+4])
                    mem[word_hi][8*i +: 8] <= wide_wdata[32+8*i +: 8];
            end
        end
    end

    // Control FSM with registered handshake and response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            lo_q      <= 32'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        f3_q      <= req_f3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (LATENCY > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 4'(LATENCY - 1);
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= ACC;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                ACC, ACC2: begin
                    if (state == ACC && split) begin
                        lo_q  <= mem[word_lo];
                        state <= ACC2;
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_fault <= fault;
                        rsp_rdata <= (fault || we_q) ? 32'd0 : ext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu at LATENCY=2; split-access checks
// are compiled in when DMEM_MISALIGN_EN is defined, misalignment faults otherwise.
module tb_dmem_lsu;
    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    dmem_lsu #(.ADDR_W(8), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_f3    (req_f3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        logic [7:0]  addr;
    } exp_t;

    exp_t sb[$];
    int   acc_cyc[$];
    int   cyc      = 0;
    int   last_acc = 0;
    int   acc_gap  = 0;
    int   n_rsp    = 0;
    int   checks   = 0;
    int   fails    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Acceptance log: cycle number of every handshake edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && req_valid && req_ready) begin
            acc_cyc.push_back(cyc);
            acc_gap  = cyc - last_acc;
            last_acc = cyc;
        end
    end

    // Response scoreboard: pop expectation on every rsp_valid pulse
    always @(negedge clk) begin : rsp_mon
        exp_t e;
        int   a;
        if (rsp_valid === 1'b1) begin
            n_rsp = n_rsp + 1;
            if (sb.size() == 0 || acc_cyc.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h, want no response", rsp_rdata);
            end else begin
                e = sb.pop_front();
                a = acc_cyc.pop_front();
                checks++;
                if (rsp_rdata !== e.rdata) begin
                    fails++;
                    $display("FAIL rdata addr=%h: got %h want %h", e.addr, rsp_rdata, e.rdata);
                end
                checks++;
                if (rsp_fault !== e.fault) begin
                    fails++;
                    $display("FAIL fault addr=%h: got %b want %b", e.addr, rsp_fault, e.fault);
                end
                checks++;
                if ((cyc - a) !== e.lat) begin
                    fails++;
                    $display("FAIL latency addr=%h: got %0d want %0d", e.addr, cyc - a, e.lat);
                end
            end
        end
    end

    // Drive one request (called at a negedge) and queue its expected response
    task automatic send(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [31:0] er, input logic ef,
                        input int lat, input bit hold);
        exp_t e;
        int   t;
        e.rdata = er; e.fault = ef; e.lat = lat; e.addr = addr;
        sb.push_back(e);
        req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        t = 0;
        while (req_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (req_ready !== 1'b1) begin
            checks++; fails++;
            $display("FAIL accept_timeout addr=%h: got req_ready=%b want 1", addr, req_ready);
            void'(sb.pop_back());
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_%s: got %0d outstanding want 0", nm, sb.size());
            sb.delete();
            acc_cyc.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0;
        req_addr = 8'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        checks++;
        if (rsp_fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", rsp_fault); end
    endtask

    task automatic test_word();
        int n;
        send(1'b1, 3'b010, 8'h10, 32'h8081_F2F3, 32'd0, 1'b0, LAT + 1, 1'b0);
        n = 0;
        while (req_ready === 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== LAT + 1) begin fails++; $display("FAIL ready_low_cycles: got %0d want %0d", n, LAT + 1); end
        send(1'b0, 3'b010, 8'h10, 32'd0, 32'h8081_F2F3, 1'b0, LAT + 1, 1'b0);
        drain("word");
    endtask

    task automatic test_lanes();
        send(1'b0, 3'b000, 8'h10, 32'd0, 32'hFFFF_FFF3, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b100, 8'h13, 32'd0, 32'h0000_0080, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b001, 8'h12, 32'd0, 32'hFFFF_8081, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b101, 8'h10, 32'd0, 32'h0000_F2F3, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b000, 8'h11, 32'd0, 32'hFFFF_FFF2, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b100, 8'h12, 32'd0, 32'h0000_0081, 1'b0, LAT + 1, 1'b0);
        drain("lanes");
    endtask

    task automatic test_stores();
        send(1'b1, 3'b010, 8'h14, 32'h1122_3344, 32'd0, 1'b0, LAT + 1, 1'b0);
        send(1'b1, 3'b000, 8'h15, 32'hFFFF_FFAA, 32'd0, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b010, 8'h14, 32'd0, 32'h1122_AA44, 1'b0, LAT + 1, 1'b0);
        send(1'b1, 3'b001, 8'h16, 32'h1234_BEEF, 32'd0, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b010, 8'h14, 32'd0, 32'hBEEF_AA44, 1'b0, LAT + 1, 1'b0);
        send(1'b1, 3'b000, 8'h17, 32'h0000_005A, 32'd0, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b010, 8'h14, 32'd0, 32'h5AEF_AA44, 1'b0, LAT + 1, 1'b0);
        drain("stores");
    endtask

    task automatic test_fault();
        send(1'b1, 3'b010, 8'h20, 32'hCAFE_F00D, 32'd0, 1'b0, LAT + 1, 1'b0);
`ifndef DMEM_MISALIGN_EN
        send(1'b0, 3'b010, 8'h21, 32'd0, 32'd0, 1'b1, LAT + 1, 1'b0);
        send(1'b0, 3'b001, 8'h23, 32'd0, 32'd0, 1'b1, LAT + 1, 1'b0);
        send(1'b1, 3'b010, 8'h22, 32'hFFFF_FFFF, 32'd0, 1'b1, LAT + 1, 1'b0);
        send(1'b1, 3'b001, 8'h21, 32'hFFFF_FFFF, 32'd0, 1'b1, LAT + 1, 1'b0);
`endif
        send(1'b0, 3'b011, 8'h20, 32'd0, 32'd0, 1'b1, LAT + 1, 1'b0);
        send(1'b0, 3'b110, 8'h20, 32'd0, 32'd0, 1'b1, LAT + 1, 1'b0);
        send(1'b1, 3'b100, 8'h20, 32'h0000_0000, 32'd0, 1'b1, LAT + 1, 1'b0);
        send(1'b1, 3'b011, 8'h20, 32'h0000_0000, 32'd0, 1'b1, LAT + 1, 1'b0);
        send(1'b0, 3'b010, 8'h20, 32'd0, 32'hCAFE_F00D, 1'b0, LAT + 1, 1'b0);
        drain("fault");
    endtask

`ifdef DMEM_MISALIGN_EN
    task automatic test_split();
        send(1'b1, 3'b010, 8'h0E, 32'hDEAD_BEEF, 32'd0, 1'b0, LAT + 2, 1'b0);
        send(1'b0, 3'b010, 8'h0E, 32'd0, 32'hDEAD_BEEF, 1'b0, LAT + 2, 1'b0);
        send(1'b0, 3'b101, 8'h0E, 32'd0, 32'h0000_BEEF, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b101, 8'h10, 32'd0, 32'h0000_DEAD, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b010, 8'h10, 32'd0, 32'h8081_DEAD, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b001, 8'h0F, 32'd0, 32'hFFFF_ADBE, 1'b0, LAT + 2, 1'b0);
        send(1'b1, 3'b010, 8'hFE, 32'h1357_9BDF, 32'd0, 1'b0, LAT + 2, 1'b0);
        send(1'b0, 3'b101, 8'h00, 32'd0, 32'h0000_1357, 1'b0, LAT + 1, 1'b0);
        send(1'b0, 3'b010, 8'hFE, 32'd0, 32'h1357_9BDF, 1'b0, LAT + 2, 1'b0);
        drain("split");
    endtask
`endif

    task automatic test_reset_inflight();
        int t;
        int pulses;
        req_we = 1'b1; req_f3 = 3'b010; req_addr = 8'h20; req_wdata = 32'h0000_0005;
        req_valid = 1'b1;
        t = 0;
        while (req_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_hold_valid: got %b want 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        acc_cyc.delete();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin fails++; $display("FAIL rst_dropped_rsp: got %0d pulses want 0", pulses); end
        checks++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        send(1'b0, 3'b010, 8'h20, 32'd0, 32'hCAFE_F00D, 1'b0, LAT + 1, 1'b0);
        drain("rst_inflight");
    endtask

    task automatic test_back_to_back();
        int base;
        base = n_rsp;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: send(1'b1, 3'b010, 8'h30, 32'h0102_0304, 32'd0, 1'b0, LAT + 1, 1'b1);
                1: send(1'b0, 3'b010, 8'h30, 32'd0, 32'h0102_0304, 1'b0, LAT + 1, 1'b1);
                2: send(1'b1, 3'b010, 8'h34, 32'hA5A5_5A5A, 32'd0, 1'b0, LAT + 1, 1'b1);
                default: send(1'b0, 3'b010, 8'h34, 32'd0, 32'hA5A5_5A5A, 1'b0, LAT + 1, 1'b1);
            endcase
            if (i > 0) begin
                checks++;
                if (acc_gap !== LAT + 2) begin
                    fails++;
                    $display("FAIL b2b_gap req%0d: got %0d want %0d", i, acc_gap, LAT + 2);
                end
            end
        end
        req_valid = 1'b0;
        drain("b2b");
        checks++;
        if ((n_rsp - base) !== 4) begin fails++; $display("FAIL b2b_rsp_count: got %0d want 4", n_rsp - base); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_stores();
        test_fault();
`ifdef DMEM_MISALIGN_EN
        test_split();
`endif
        test_reset_inflight();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
